// File: rtl/flash_rom_ctrl.sv
// ============================================================================
// Module   : flash_rom_ctrl
// Purpose  : Parallel NOR flash read controller for the ECO32 bus. Optional
//            one-entry word cache is enabled with the ROM_CACHE_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_rom_ctrl #(
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 6,
    parameter int PAGE_WAIT   = 6,
    parameter int SWAP        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       data_out,
    output logic              wt,
    output logic              wr_err,
    input  logic              spi_en,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              byte_n,
    output logic [ADDR_W-1:0] a,
    input  logic [15:0]       d
);

    localparam int MAX_WAIT = (WAIT_CYCLES > PAGE_WAIT) ? WAIT_CYCLES : PAGE_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] c_CNT_FIRST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_PAGE  = CNT_W'(PAGE_WAIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT1 = 2'd1;
    localparam logic [1:0] c_WAIT2 = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic             r_a1_q,    w_a1_d;
    logic             r_wt_q,    w_wt_d;
    logic             r_wr_err_q, w_wr_err_d;
    logic [31:0]      r_data_q,  w_data_d;

    logic [15:0] w_hw;
    logic        w_cnt_zero;
    logic        w_fetch_word;

    // Normalise the flash halfword so [15:8] is always the lower-addressed byte.
    assign w_hw       = (SWAP != 0) ? {d[7:0], d[15:8]} : d;
    assign w_cnt_zero = (r_cnt_q == '0);

`ifdef ROM_CACHE_EN
    logic              r_cvalid_q, w_cvalid_d;
    logic [ADDR_W-3:0] r_ctag_q,   w_ctag_d;
    logic [31:0]       r_cword_q,  w_cword_d;
    logic              w_hit;

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  lo);
        logic [15:0] h;
        h = lo[1] ? word[15:0] : word[31:16];
        if (sz[1])
            extract = word;
        else if (sz[0])
            extract = {16'h0, h};
        else
            extract = {24'h0, lo[0] ? h[7:0] : h[15:8]};
    endfunction

    assign w_hit        = r_cvalid_q && (r_ctag_q == addr[ADDR_W-1:2]);
    // Misses always fetch the whole word so the cache can be filled.
    assign w_fetch_word = 1'b1;
`else
    logic [7:0] w_byte;
    assign w_byte       = addr[0] ? w_hw[7:0] : w_hw[15:8];
    assign w_fetch_word = size[1];
`endif

    always_ff @(posedge clk) begin : p_state_reg
        if (reset) begin
            r_state_q  <= c_IDLE;
            r_cnt_q    <= '0;
            r_a1_q     <= 1'b0;
            r_wt_q     <= 1'b1;
            r_wr_err_q <= 1'b0;
            r_data_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_a1_q     <= w_a1_d;
            r_wt_q     <= w_wt_d;
            r_wr_err_q <= w_wr_err_d;
            r_data_q   <= w_data_d;
        end
    end

`ifdef ROM_CACHE_EN
    always_ff @(posedge clk) begin : p_cache_reg
        if (reset) begin
            r_cvalid_q <= 1'b0;
            r_ctag_q   <= '0;
            r_cword_q  <= '0;
        end else begin
            r_cvalid_q <= w_cvalid_d;
            r_ctag_q   <= w_ctag_d;
            r_cword_q  <= w_cword_d;
        end
    end
`endif

    always_comb begin : p_next_state
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            c_IDLE: begin
                if (en) begin
                    if (wr) begin
                        w_state_d = c_DONE;
                    end else if (!spi_en) begin
`ifdef ROM_CACHE_EN
                        if (w_hit) begin
                            w_state_d = c_DONE;
                        end else begin
                            w_state_d = c_WAIT1;
                            w_cnt_d   = c_CNT_FIRST;
                        end
`else
                        w_state_d = c_WAIT1;
                        w_cnt_d   = c_CNT_FIRST;
`endif
                    end
                end
            end
            c_WAIT1: begin
                if (w_cnt_zero) begin
                    if (w_fetch_word) begin
                        w_state_d = c_WAIT2;
                        w_cnt_d   = c_CNT_PAGE;
                    end else begin
                        w_state_d = c_DONE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            c_WAIT2: begin
                if (w_cnt_zero)
                    w_state_d = c_DONE;
                else
                    w_cnt_d = r_cnt_q - CNT_W'(1);
            end
            c_DONE:  w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        w_a1_d     = r_a1_q;
        w_wt_d     = r_wt_q;
        w_wr_err_d = r_wr_err_q;
        w_data_d   = r_data_q;
`ifdef ROM_CACHE_EN
        w_cvalid_d = r_cvalid_q;
        w_ctag_d   = r_ctag_q;
        w_cword_d  = r_cword_q;
`endif
        case (r_state_q)
            c_IDLE: begin
                if (en) begin
                    if (wr) begin
                        w_wt_d     = 1'b0;
                        w_wr_err_d = 1'b1;
                    end else if (!spi_en) begin
`ifdef ROM_CACHE_EN
                        if (w_hit) begin
                            w_wt_d   = 1'b0;
                            w_data_d = extract(r_cword_q, size, addr[1:0]);
                        end else begin
                            w_a1_d = 1'b0;
                        end
`else
                        w_a1_d = size[1] ? 1'b0 : addr[1];
`endif
                    end
                end
            end
            c_WAIT1: begin
                if (w_cnt_zero) begin
`ifdef ROM_CACHE_EN
                    w_a1_d            = 1'b1;
                    w_cword_d[31:16]  = w_hw;
                    w_cvalid_d        = 1'b0;
`else
                    if (size[1]) begin
                        w_a1_d          = 1'b1;
                        w_data_d[31:16] = w_hw;
                    end else begin
                        w_wt_d   = 1'b0;
                        w_data_d = size[0] ? {16'h0, w_hw} : {24'h0, w_byte};
                    end
`endif
                end
            end
            c_WAIT2: begin
                if (w_cnt_zero) begin
                    w_wt_d = 1'b0;
`ifdef ROM_CACHE_EN
                    w_data_d         = extract({r_cword_q[31:16], w_hw}, size, addr[1:0]);
                    w_cword_d[15:0]  = w_hw;
                    w_cvalid_d       = 1'b1;
                    w_ctag_d         = addr[ADDR_W-1:2];
`else
                    w_data_d[15:0] = w_hw;
`endif
                end
            end
            c_DONE: begin
                w_wt_d     = 1'b1;
                w_wr_err_d = 1'b0;
            end
            default: ;
        endcase
`ifdef ROM_CACHE_EN
        // SPI traffic may reprogram the flash, so the cached word is dropped.
        if (spi_en)
            w_cvalid_d = 1'b0;
`endif
    end

    assign data_out = r_data_q;
    assign wt       = r_wt_q;
    assign wr_err   = r_wr_err_q;
    assign ce_n     = spi_en;
    assign oe_n     = spi_en;
    assign we_n     = 1'b1;
    assign byte_n   = 1'b1;
    assign a        = {addr[ADDR_W-1:2], r_a1_q, 1'b0};

endmodule

`default_nettype wire

// File: tb/tb_flash_rom_ctrl.sv
// ============================================================================
// Module   : tb_flash_rom_ctrl
// Purpose  : Self-checking bench for flash_rom_ctrl against a byte-addressed
//            big-endian flash model with access and page timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_rom_ctrl;

    localparam int AW = 24;
    localparam int WC = 6;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   data_out;
    logic          wt;
    logic          wr_err;
    logic          spi_en;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic          byte_n;
    logic [AW-1:0] a;
    logic [15:0]   d;

    flash_rom_ctrl #(
        .ADDR_W(AW), .WAIT_CYCLES(WC), .PAGE_WAIT(PW), .SWAP(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .wr(wr), .size(size), .addr(addr),
        .data_out(data_out), .wt(wt), .wr_err(wr_err), .spi_en(spi_en),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .byte_n(byte_n), .a(a), .d(d)
    );

    always #5 clk = ~clk;

    // Flash array: halfword index a[10:1]; low pin lane holds the even byte.
    logic [15:0] flash [0:1023];

    // Data is only valid once the upper address has been stable for the
    // access time and a1 has been stable for the page time; otherwise junk.
    logic [AW-3:0] last_hi;
    logic          last_a1;
    int            age_hi = 0;
    int            age_lo = 0;

    always @(negedge clk) begin
        if (a[AW-1:2] !== last_hi) begin
            last_hi <= a[AW-1:2];
            age_hi  <= 1;
        end else if (age_hi < 1000) begin
            age_hi <= age_hi + 1;
        end
        if (a[1] !== last_a1) begin
            last_a1 <= a[1];
            age_lo  <= 1;
        end else if (age_lo < 1000) begin
            age_lo <= age_lo + 1;
        end
    end

    assign d = (age_hi >= WC && age_lo >= PW) ? flash[a[10:1]] : ~flash[a[10:1]];

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_data;
    logic        exp_a1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] x);
        logic [15:0] h;
        h = flash[x[10:1]];
        return x[0] ? h[15:8] : h[7:0];
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] ad, input logic [1:0] sz);
        logic [AW-1:0] base;
        if (sz[1]) begin
            base = {ad[AW-1:2], 2'b00};
            return {mem_byte(base), mem_byte(base + 1), mem_byte(base + 2), mem_byte(base + 3)};
        end else if (sz[0]) begin
            base = {ad[AW-1:1], 1'b0};
            return {16'h0, mem_byte(base), mem_byte(base + 1)};
        end
        return {24'h0, mem_byte(ad)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [AW-1:0] ad, input logic [1:0] sz, input logic w);
        en   = 1'b1;
        wr   = w;
        size = sz;
        addr = ad;
    endtask

    // Called just after the request is driven; the next edge accepts it.
    task automatic finish_req(input logic [AW-1:0] ad, input logic [1:0] sz, input logic w);
        int lat;
        int exp_lat;
        step();
        if (w)
            check("a_hold_on_write", 32'(a), 32'({ad[AW-1:2], exp_a1, 1'b0}));
        else
            check("a_first", 32'(a), 32'({ad[AW-1:2], sz[1] ? 1'b0 : ad[1], 1'b0}));
        lat = 0;
        while (wt !== 1'b0 && lat < 200) begin
            step();
            lat++;
        end
        exp_lat = w ? 0 : (sz[1] ? WC + PW : WC);
        check("latency", 32'(lat), 32'(exp_lat));
        if (!w) begin
            exp_data = model_read(ad, sz);
            exp_a1   = sz[1] ? 1'b1 : ad[1];
        end
        check("data_out", data_out, exp_data);
        check("wr_err", {31'h0, wr_err}, {31'h0, w});
        en = 1'b0;
        step();
        check("wt_release", {31'h0, wt}, 32'h1);
        check("wr_err_clear", {31'h0, wr_err}, 32'h0);
    endtask

    task automatic access(input logic [AW-1:0] ad, input logic [1:0] sz, input logic w);
        start_req(ad, sz, w);
        finish_req(ad, sz, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        any_low;
        logic [AW-1:0] rad;
        logic [1:0]  rsz;
        logic        rw;

        for (int i = 0; i < 1024; i++)
            flash[i] = 16'($urandom);
        flash[10'h081] = 16'h3412;
        flash[10'h100] = 16'hBBAA;
        flash[10'h101] = 16'hDDCC;
        flash[10'h180] = 16'h5A7F;

        reset  = 1'b1;
        en     = 1'b0;
        wr     = 1'b0;
        size   = 2'b00;
        addr   = '0;
        spi_en = 1'b0;
        exp_data = 32'h0;
        exp_a1   = 1'b0;
        repeat (3) step();
        check("rst_wt", {31'h0, wt}, 32'h1);
        check("rst_wr_err", {31'h0, wr_err}, 32'h0);
        check("rst_data", data_out, 32'h0);
        check("rst_a", 32'(a), 32'h0);
        check("pins_idle", {28'h0, ce_n, oe_n, we_n, byte_n}, 32'h3);
        reset = 1'b0;
        step();

        access(24'h000102, 2'b01, 1'b0);
        check("hw_0102_value", data_out, 32'h00001234);
        access(24'h000200, 2'b10, 1'b0);
        check("word_0200_value", data_out, 32'hAABBCCDD);
        access(24'h000301, 2'b00, 1'b0);
        check("byte_0301_value", data_out, 32'h0000005A);
        access(24'h000300, 2'b00, 1'b0);
        check("byte_0300_value", data_out, 32'h0000007F);
        access(24'h000304, 2'b11, 1'b1);

        // Request held off while SPI owns the bus.
        spi_en = 1'b1;
        start_req(24'h000102, 2'b01, 1'b0);
        any_low = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wt !== 1'b1) any_low = 1'b1;
        end
        check("spi_hold_wt", {31'h0, any_low}, 32'h0);
        check("spi_pins", {30'h0, ce_n, oe_n}, 32'h3);
        spi_en = 1'b0;
        finish_req(24'h000102, 2'b01, 1'b0);

        // Reset in the middle of a read: no completion pulse afterwards.
        start_req(24'h0007F6, 2'b01, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        en    = 1'b0;
        step();
        reset = 1'b0;
        exp_data = 32'h0;
        exp_a1   = 1'b0;
        check("midrst_wt", {31'h0, wt}, 32'h1);
        check("midrst_data", data_out, 32'h0);
        check("midrst_a", 32'(a), 32'({addr[AW-1:2], 2'b00}));
        any_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wt !== 1'b1) any_low = 1'b1;
        end
        check("midrst_no_pulse", {31'h0, any_low}, 32'h0);
        access(24'h0007F6, 2'b01, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rad = AW'($urandom);
            rsz = 2'($urandom_range(0, 3));
            rw  = ($urandom_range(0, 4) == 0);
            access(rad, rsz, rw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
